// File: rtl/pc_gen_unit.sv
// Fetch program-counter generator: boot PC, sequential fetch, branch prediction,
// early-jump and backend redirects, and halt control.

package len5_pkg;
    localparam int unsigned XLEN = 64;
endpackage

package fetch_pkg;
    typedef struct packed {
        logic [len5_pkg::XLEN-1:0] pc;
        logic [len5_pkg::XLEN-1:0] target;
        logic                      taken;
    } prediction_t;
endpackage

// state | meaning
// ------+--------------------------------------------------------------
// RESET | PC loaded with BOOT_PC, no request issued
// FETCH | fetch request presented at pc_o, advances when accepted
// HALT  | no request issued, PC held (redirects still applied)
module pc_gen_unit #(
    parameter logic [63:0] BOOT_PC = 64'h0,
    parameter int unsigned XLEN    = len5_pkg::XLEN
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   halt_i,
    input  fetch_pkg::prediction_t bpu_pred_i,
    input  logic                   early_jump_valid_i,
    input  logic                   early_jump_flush_i,
    input  logic [XLEN-1:0]        early_jump_base_i,
    input  logic [XLEN-1:0]        early_jump_offs_i,
    output logic [XLEN-1:0]        early_jump_target_o,
    input  logic                   res_mispredict_i,
    input  logic [XLEN-1:0]        res_target_i,
    input  logic                   mem_ready_i,
    output logic                   mem_valid_o,
    output logic [XLEN-1:0]        pc_o,
    output logic                   mem_flush_o
);

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state_q;
    logic            mem_valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] jump_sum;
    logic            accepted;

    // The predictor's own pc tag is informational; the prediction is taken as
    // belonging to the address currently presented.
    logic unused_pred_pc;
    assign unused_pred_pc = ^bpu_pred_i.pc;

    assign jump_sum            = early_jump_base_i + early_jump_offs_i;
    assign early_jump_target_o = {jump_sum[XLEN-1:1], 1'b0};
    assign mem_flush_o         = res_mispredict_i;
    assign accepted            = mem_valid_q && mem_ready_i;

    always_comb begin
        pc_next = pc_q;
        if (res_mispredict_i) begin
            pc_next = res_target_i;
        end else if (early_jump_valid_i && early_jump_flush_i) begin
            pc_next = early_jump_target_o;
        end else if (accepted && bpu_pred_i.taken) begin
            pc_next = bpu_pred_i.target[XLEN-1:0];
        end else if (accepted) begin
            pc_next = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RESET;
            mem_valid_q <= 1'b0;
            pc_q        <= BOOT_PC[XLEN-1:0];
        end else begin
            pc_q <= pc_next;
            case (state_q)
                RESET: begin
                    state_q     <= FETCH;
                    mem_valid_q <= 1'b1;
                end
                FETCH: begin
                    if (halt_i) begin
                        state_q     <= HALT;
                        mem_valid_q <= 1'b0;
                    end else begin
                        mem_valid_q <= 1'b1;
                    end
                end
                HALT: begin
                    if (!halt_i) begin
                        state_q     <= FETCH;
                        mem_valid_q <= 1'b1;
                    end else begin
                        mem_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= RESET;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_valid_o = mem_valid_q;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios plus randomized
// traffic checked against a cycle-level reference model.

module tb_pc_gen_unit;

    localparam logic [63:0] BOOT = 64'h1000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   halt;
    fetch_pkg::prediction_t pred;
    logic                   ej_valid;
    logic                   ej_flush;
    logic [63:0]            ej_base;
    logic [63:0]            ej_offs;
    logic [63:0]            ej_target;
    logic                   misp;
    logic [63:0]            res_target;
    logic                   mem_ready;
    logic                   mem_valid;
    logic [63:0]            pc;
    logic                   mem_flush;

    int checks = 0;
    int errors = 0;

    // reference model: fetch phase (0 reset, 1 fetching, 2 halted) and PC
    int          m_phase = 0;
    logic [63:0] m_pc    = BOOT;

    always #5 clk = ~clk;

    pc_gen_unit #(.BOOT_PC(BOOT), .XLEN(64)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .halt_i              (halt),
        .bpu_pred_i          (pred),
        .early_jump_valid_i  (ej_valid),
        .early_jump_flush_i  (ej_flush),
        .early_jump_base_i   (ej_base),
        .early_jump_offs_i   (ej_offs),
        .early_jump_target_o (ej_target),
        .res_mispredict_i    (misp),
        .res_target_i        (res_target),
        .mem_ready_i         (mem_ready),
        .mem_valid_o         (mem_valid),
        .pc_o                (pc),
        .mem_flush_o         (mem_flush)
    );

    task automatic idle_inputs();
        rst = 0; halt = 0; pred = '0; ej_valid = 0; ej_flush = 0;
        ej_base = '0; ej_offs = '0; misp = 0; res_target = '0; mem_ready = 0;
    endtask

    // advance one clock edge; the model computes its next values from the
    // inputs as they stand just before the edge
    task automatic tick();
        logic [63:0] npc;
        int          nph;
        bit          acc;
        acc = (m_phase == 1) && mem_ready;
        npc = m_pc;
        nph = m_phase;
        if (rst) begin
            npc = BOOT;
            nph = 0;
        end else begin
            if (misp)                      npc = res_target;
            else if (ej_valid && ej_flush) npc = (ej_base + ej_offs) & ~64'h1;
            else if (acc && pred.taken)    npc = pred.target;
            else if (acc)                  npc = m_pc + 64'd4;
            if (m_phase == 0)      nph = 1;
            else if (m_phase == 1) nph = halt ? 2 : 1;
            else                   nph = halt ? 2 : 1;
        end
        @(posedge clk);
        m_pc    = npc;
        m_phase = nph;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; misp = 1; res_target = 64'hDEAD_0000; ej_valid = 1; ej_flush = 1;
        tick();
        checks++; if (pc !== BOOT) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, BOOT); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_valid); end
        checks++; if (mem_flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b want 1", mem_flush); end
        idle_inputs();
        mem_ready = 1;
        tick();
        checks++; if (mem_valid !== 1'b1 || pc !== 64'h1000) begin errors++; $display("FAIL boot_seq0: valid %b pc %h want 1 1000", mem_valid, pc); end
        checks++; if (mem_flush !== 1'b0) begin errors++; $display("FAIL idle_flush: got %b want 0", mem_flush); end
        tick();
        checks++; if (pc !== 64'h1004) begin errors++; $display("FAIL boot_seq1: got %h want 1004", pc); end
        tick();
        checks++; if (pc !== 64'h1008) begin errors++; $display("FAIL boot_seq2: got %h want 1008", pc); end
    endtask

    task automatic test_bpu();
        idle_inputs();
        misp = 1; res_target = 64'h2000;
        tick();
        checks++; if (pc !== 64'h2000) begin errors++; $display("FAIL bpu_setup: got %h want 2000", pc); end
        idle_inputs();
        pred.taken = 1; pred.target = 64'h3000; pred.pc = 64'h2000;
        tick();
        checks++; if (pc !== 64'h2000) begin errors++; $display("FAIL bpu_not_accepted: got %h want 2000", pc); end
        mem_ready = 1;
        tick();
        checks++; if (pc !== 64'h3000) begin errors++; $display("FAIL bpu_taken: got %h want 3000", pc); end
    endtask

    task automatic test_early_jump();
        idle_inputs();
        misp = 1; res_target = 64'h1234_0000;
        tick();
        idle_inputs();
        ej_valid = 1; ej_base = 64'h4000; ej_offs = 64'hFFFF_FFFF_FFFF_FFF8;
        for (int c = 1; c <= 3; c++) begin
            ej_flush = (c == 3);
            tick();
            if (c < 3) begin
                checks++; if (pc !== 64'h1234_0000) begin errors++; $display("FAIL ej_wait%0d: got %h want 12340000", c, pc); end
            end else begin
                checks++; if (pc !== 64'h3FF8) begin errors++; $display("FAIL ej_redirect: got %h want 3ff8", pc); end
            end
        end
        ej_flush = 0;
        tick();
        checks++; if (pc !== 64'h3FF8) begin errors++; $display("FAIL ej_single: got %h want 3ff8", pc); end
        ej_valid = 0; ej_base = 64'h0; ej_offs = 64'h5001;
        #1;
        checks++; if (ej_target !== 64'h5000) begin errors++; $display("FAIL ej_target_lsb: got %h want 5000", ej_target); end
    endtask

    task automatic test_mispredict_priority();
        idle_inputs();
        misp = 1; res_target = 64'h8000;
        ej_valid = 1; ej_flush = 1; ej_base = 64'h9000; ej_offs = 64'h0;
        #1;
        checks++; if (mem_flush !== 1'b1) begin errors++; $display("FAIL misp_flush: got %b want 1", mem_flush); end
        tick();
        checks++; if (pc !== 64'h8000 || mem_valid !== 1'b1) begin errors++; $display("FAIL misp_wins: pc %h valid %b want 8000 1", pc, mem_valid); end
    endtask

    task automatic test_wrap();
        idle_inputs();
        misp = 1; res_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        idle_inputs();
        mem_ready = 1;
        tick();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL pc_wrap: got %h want 0", pc); end
    endtask

    task automatic test_halt();
        idle_inputs();
        misp = 1; res_target = 64'h100;
        tick();
        idle_inputs();
        halt = 1;
        tick();
        checks++; if (mem_valid !== 1'b0 || pc !== 64'h100) begin errors++; $display("FAIL halt_enter: valid %b pc %h want 0 100", mem_valid, pc); end
        misp = 1; res_target = 64'h200; mem_ready = 1;
        tick();
        checks++; if (mem_valid !== 1'b0 || pc !== 64'h200) begin errors++; $display("FAIL halt_redirect: valid %b pc %h want 0 200", mem_valid, pc); end
        misp = 0;
        tick();
        checks++; if (pc !== 64'h200) begin errors++; $display("FAIL halt_hold: got %h want 200", pc); end
        halt = 0;
        tick();
        checks++; if (mem_valid !== 1'b1 || pc !== 64'h200) begin errors++; $display("FAIL halt_resume: valid %b pc %h want 1 200", mem_valid, pc); end
        tick();
        checks++; if (pc !== 64'h204) begin errors++; $display("FAIL halt_next: got %h want 204", pc); end
        halt = 1;
        tick();
        rst = 1;
        tick();
        checks++; if (pc !== BOOT || mem_valid !== 1'b0) begin errors++; $display("FAIL halt_reset: pc %h valid %b want 1000 0", pc, mem_valid); end
        rst = 0; halt = 0;
        tick();
        checks++; if (pc !== BOOT || mem_valid !== 1'b1) begin errors++; $display("FAIL post_reset: pc %h valid %b want 1000 1", pc, mem_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            halt       = ($urandom_range(0, 9) == 0);
            mem_ready  = ($urandom_range(0, 3) != 0);
            misp       = ($urandom_range(0, 11) == 0);
            res_target = {$urandom, $urandom};
            ej_valid   = ($urandom_range(0, 5) == 0);
            ej_flush   = $urandom_range(0, 1) == 1;
            ej_base    = {$urandom, $urandom};
            ej_offs    = {$urandom, $urandom};
            pred.taken  = ($urandom_range(0, 3) == 0);
            pred.target = {$urandom, $urandom};
            pred.pc     = {$urandom, $urandom};
            #1;
            checks++; if (ej_target !== ((ej_base + ej_offs) & ~64'h1)) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", i, ej_target, (ej_base + ej_offs) & ~64'h1); end
            checks++; if (mem_flush !== misp) begin errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, mem_flush, misp); end
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
            checks++; if (mem_valid !== (m_phase == 1)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, mem_valid, m_phase == 1); end
        end
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_bpu();
        test_early_jump();
        test_mispredict_priority();
        test_wrap();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 SHALL have parameter BOOT_PC, default 64'h0, PC loaded on reset.
REQ-002 SHALL have parameter XLEN, default len5_pkg::XLEN (64), width of all address ports.
REQ-003 SHALL have port clk_i  in  1  clock; single clock domain, all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port halt_i  in  1  stop issuing fetch requests while high.
REQ-006 SHALL have port bpu_pred_i  in  fetch_pkg::prediction_t  branch prediction for the current pc_o (pc, target, taken).
REQ-007 SHALL have port early_jump_valid_i  in  1  early jump detected by the jump early decoder.
REQ-008 SHALL have port early_jump_flush_i  in  1  early jump accepted by issue; redirect may be applied.
REQ-009 SHALL have port early_jump_base_i  in  XLEN  early jump base address.
REQ-010 SHALL have port early_jump_offs_i  in  XLEN  early jump offset.
REQ-011 SHALL have port early_jump_target_o  out  XLEN  computed early jump target, returned to the early decoder.
REQ-012 SHALL have port res_mispredict_i  in  1  backend misprediction resolution valid.
REQ-013 SHALL have port res_target_i  in  XLEN  correct target from the backend.
REQ-014 SHALL have port mem_ready_i  in  1  fetch memory interface accepts a request.
REQ-015 SHALL have port mem_valid_o  out  1  fetch request valid.
REQ-016 SHALL have port pc_o  out  XLEN  fetch address.
REQ-017 SHALL have port mem_flush_o  out  1  discard in-flight fetches (backend redirect).

Function
REQ-018 early_jump_target_o SHALL be combinational (early_jump_base_i + early_jump_offs_i) modulo 2^XLEN, bit 0 forced to 0.
REQ-019 SHALL implement FSM states RESET, FETCH, HALT; RESET->FETCH unconditionally after one cycle; FETCH->HALT when halt_i; HALT->FETCH when !halt_i.
REQ-020 mem_valid_o SHALL be 1 only in FETCH; 0 in RESET and HALT.
REQ-021 A request SHALL be accepted in a cycle with mem_valid_o && mem_ready_i.
REQ-022 Next-PC priority, highest first: res_mispredict_i -> res_target_i; early_jump_valid_i && early_jump_flush_i -> early_jump_target_o; accepted request with bpu_pred_i.taken -> bpu_pred_i.target; accepted request -> pc_o + 4; otherwise hold pc_o.
REQ-023 Backend and early-jump redirects SHALL update pc_o next cycle regardless of state or mem_ready_i; in HALT the new PC is held until FETCH resumes.
REQ-024 early_jump_valid_i without early_jump_flush_i SHALL not change pc_o (jump waiting for issue; multi-cycle valid causes exactly one redirect).
REQ-025 mem_flush_o SHALL equal res_mispredict_i combinationally; 0 otherwise.
REQ-026 Simultaneous res_mispredict_i and early jump: backend redirect wins, early jump dropped.
REQ-027 Redirect while mem_valid_o && !mem_ready_i: pc_o changes next cycle with mem_valid_o still 1; the memory interface tolerates the address change.
REQ-028 pc_o + 4 SHALL wrap modulo 2^XLEN (all-ones-minus-3 -> 0).
REQ-029 bpu_pred_i SHALL be ignored when no request is accepted.
REQ-030 halt_i SHALL not block redirects; halt and redirect in the same cycle apply both.

Reset
REQ-031 rst_i high at a clock edge SHALL set state RESET and pc_o = BOOT_PC, overriding all inputs including redirects.
REQ-032 During and one cycle after reset: mem_valid_o = 0, mem_flush_o follows res_mispredict_i; reset mid-operation aborts any pending request without completion.
REQ-033 No output SHALL be X after the first reset edge.

Verification
REQ-034 Reset BOOT_PC=0x1000, mem_ready_i=1, no predictions -> pc_o 0x1000, 0x1004, 0x1008 on consecutive FETCH cycles, mem_valid_o low for first cycle.
REQ-035 pc_o=0x2000 accepted, bpu taken target 0x3000 -> pc_o 0x3000 next cycle; same with mem_ready_i=0 -> pc_o stays 0x2000.
REQ-036 early_jump_valid_i=1 for 3 cycles, flush only on cycle 3, base 0x4000 offs -8 -> pc_o unchanged cycles 1-2, 0x3FF8 after cycle 3, single redirect.
REQ-037 base 0, offs 0x5001 -> early_jump_target_o 0x5000.
REQ-038 res_mispredict_i target 0x8000 with concurrent early jump to 0x9000 and mem_ready_i=0 -> mem_flush_o=1 that cycle, pc_o=0x8000 next.
REQ-039 halt_i=1 at pc 0x100, redirect to 0x200 during halt, then release -> mem_valid_o 0 in HALT, first request after release at 0x200; rst_i mid-halt -> pc_o BOOT_PC.
